// File: rtl/mem_req_sequencer_pkg.sv
// Shared types for the memory request sequencer.
// Request bundle, FSM states and cache mode encoding.
package mem_seq_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    CAPTURE,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              mode;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/mem_req_sequencer_if.sv
// Request, response and cache-side signals of the sequencer.
// slave = sequencer view, master = processor/cache view.
interface mem_req_sequencer_if;
  import mem_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_mode;

  logic [ADDR_W-1:0] cache_address;
  logic [DATA_W-1:0] cache_data;
  logic              cache_mode;
  logic [DATA_W-1:0] cache_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  logic              busy;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  req_mode,
    input  cache_out,
    input  rsp_ready,
    output req_ready,
    output cache_address,
    output cache_data,
    output cache_mode,
    output rsp_valid,
    output rsp_data,
    output busy
  );

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    output req_mode,
    output cache_out,
    output rsp_ready,
    input  req_ready,
    input  cache_address,
    input  cache_data,
    input  cache_mode,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

endinterface

// File: rtl/mem_req_sequencer_req_fifo.sv
// Request FIFO: power-of-two depth, wrapping pointers,
// occupancy counter driving full/empty.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// Feeds buffered requests to the cache one at a time,
// holds cache inputs stable and returns read data.
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int RD_LAT  = 2,
  parameter int WR_HOLD = 1
) (
  input logic                clk,
  input logic                rst_n,
  mem_req_sequencer_if.slave bus
);

  localparam int MAXC  = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_HOLD - 1);

  req_t w_req_in;
  req_t w_head;
  logic w_full;
  logic w_empty;
  logic w_pop;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [ADDR_W-1:0] r_cache_addr;
  logic [DATA_W-1:0] r_cache_data;
  logic              r_cache_mode;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  assign w_req_in.addr = bus.req_addr;
  assign w_req_in.data = bus.req_data;
  assign w_req_in.mode = bus.req_mode;

  req_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.req_valid),
    .i_data  (w_req_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = HOLD;
          w_cnt_nxt   = (w_head.mode == MODE_WR)
                      ? WR_LOAD : RD_LOAD;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = (r_cache_mode == MODE_WR)
                      ? IDLE : CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      CAPTURE: w_state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Cache inputs move only on issue: any other toggle
  // would look like a fresh request to the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_addr <= '0;
      r_cache_data <= '0;
      r_cache_mode <= MODE_RD;
    end else if (w_pop) begin
      r_cache_addr <= w_head.addr;
      r_cache_data <= w_head.data;
      r_cache_mode <= w_head.mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == CAPTURE) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= bus.cache_out;
    end else if (r_state == RESP && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready     = !w_full;
  assign bus.cache_address = r_cache_addr;
  assign bus.cache_data    = r_cache_data;
  assign bus.cache_mode    = r_cache_mode;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.busy          = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer with a change-triggered
// cache model and an in-order response scoreboard.
module tb_mem_req_sequencer;
  import mem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_sequencer_if bus();

  mem_req_sequencer #(
    .DEPTH   (4),
    .RD_LAT  (2),
    .WR_HOLD (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int wr_cnt = 0;
  int exp_wr = 0;
  int acc_cyc = 0;

  logic [31:0] ram [256];
  logic [31:0] exp_ram [256];
  logic [31:0] exp_q [$];
  int chg_q [$];
  logic [64:0] prev_in = '0;
  logic [64:0] last_cs = '0;
  logic prev_v = 1'b0;

  function automatic logic [31:0] pre(input int a);
    return 32'hA000_0000 | (a * 32'h0101);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cache acts only when its inputs differ from the last edge.
  always @(posedge clk) begin
    logic [64:0] cur;
    cur = {bus.cache_address, bus.cache_data, bus.cache_mode};
    if (cur != prev_in) begin
      if (bus.cache_mode == MODE_WR) begin
        ram[bus.cache_address[7:0]] = bus.cache_data;
        wr_cnt++;
      end else begin
        bus.cache_out <= ram[bus.cache_address[7:0]];
      end
    end
    prev_in = cur;
  end

  always @(negedge clk) begin
    logic [64:0] cs;
    logic [31:0] e;
    cs = {bus.cache_address, bus.cache_data, bus.cache_mode};
    if (cs != last_cs) chg_q.push_back(cyc);
    last_cs = cs;
    if (bus.rsp_valid && !prev_v) rise_cyc = cyc;
    prev_v = bus.rsp_valid;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got %h, none expected",
                 bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_data !== e) begin
          n_bad++;
          $display("FAIL rsp_data: got %h expected %h",
                   bus.rsp_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic m);
    int n;
    n = 0;
    if (m == MODE_RD) begin
      exp_q.push_back(exp_ram[a[7:0]]);
    end else begin
      exp_ram[a[7:0]] = d;
      exp_wr++;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_mode  = m;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("req_accept_timeout", 64'(n), 64'(0));
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({"drain_", nm}, 64'(n < max), 64'(1));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i] = pre(i);
      exp_ram[i] = pre(i);
    end
    ram[5] = 32'hA5A5_A5A5;
    exp_ram[5] = 32'hA5A5_A5A5;
    bus.cache_out = '0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_mode  = MODE_RD;
    bus.rsp_ready = 1'b1;

    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_cache_addr", 64'(bus.cache_address), 64'(0));
    chk("rst_cache_data", 64'(bus.cache_data), 64'(0));
    chk("rst_cache_mode", 64'(bus.cache_mode), 64'(0));

    chg_q.delete();
    rise_cyc = -1;
    send(32'd5, 32'd0, MODE_RD);
    n = acc_cyc;
    drain("t1", 50);
    chk("t1_latency", 64'(rise_cyc - n), 64'(4));
    chk("t1_cache_changes", 64'(chg_q.size()), 64'(1));

    idle(2);
    chg_q.delete();
    send(32'd7, 32'h1234_5678, MODE_WR);
    send(32'd7, 32'd0, MODE_RD);
    drain("t2", 50);
    chk("t2_cache_changes", 64'(chg_q.size()), 64'(2));
    if (chg_q.size() == 2)
      chk("t2_wr_hold", 64'(chg_q[1] - chg_q[0]), 64'(2));

    idle(2);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(32'(10 + i), 32'd0, MODE_RD);
    chk("t3_full_ready", 64'(bus.req_ready), 64'(0));
    chk("t3_busy", 64'(bus.busy), 64'(1));
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      idle(1);
      n++;
    end
    chk("t4_rsp_seen", 64'(bus.rsp_valid), 64'(1));
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("t4_hold_valid", 64'(bus.rsp_valid), 64'(1));
      chk("t4_hold_data", 64'(bus.rsp_data), 64'(pre(10)));
      chk("t4_hold_caddr", 64'(bus.cache_address), 64'(10));
    end
    bus.rsp_ready = 1'b1;
    drain("t3", 100);

    idle(2);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(32'(20 + i), 32'd0, MODE_RD);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (bus.cache_address != 32'd21 && n < 50) begin
      idle(1);
      n++;
    end
    chk("t5_b_issued", 64'(bus.cache_address), 64'(21));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_req_ready", 64'(bus.req_ready), 64'(1));
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t5_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("t5_busy", 64'(bus.busy), 64'(0));
    chk("t5_cache_addr", 64'(bus.cache_address), 64'(0));
    chk("t5_cache_mode", 64'(bus.cache_mode), 64'(0));
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("t5_post_busy", 64'(bus.busy), 64'(0));
    chk("t5_post_valid", 64'(bus.rsp_valid), 64'(0));

    for (int k = 1; k <= 20; k++) begin
      send(32'd3, 32'd0, MODE_RD);
      send(32'd3, 32'(k), MODE_WR);
      send(32'd3, 32'd0, MODE_RD);
    end
    drain("t6", 400);
    chk("t6_wr_count", 64'(wr_cnt), 64'(exp_wr));
    chk("t6_ram3", 64'(ram[3]), 64'(20));
    chk("t6_ram7", 64'(ram[7]), 64'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
